// File: rtl/rptr_empty_if.sv
// Read-side signal bundle between the FIFO read pointer logic and its consumer.
// The slave modport is the rptr_empty block; the master is whatever drives it.
interface rptr_empty_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  rinc;
  logic [ADDR_WIDTH:0]   rq2_wptr;
  logic                  clr_err;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [ADDR_WIDTH:0]   rptr;
  logic                  rempty;
  logic                  raempty;
  logic [ADDR_WIDTH:0]   rlevel;
  logic                  runderflow;

  modport master (
    output rinc, rq2_wptr, clr_err,
    input  raddr, rptr, rempty, raempty, rlevel, runderflow
  );

  modport slave (
    input  rinc, rq2_wptr, clr_err,
    output raddr, rptr, rempty, raempty, rlevel, runderflow
  );
endinterface

// File: rtl/rptr_empty.sv
// Async FIFO read-side pointer: binary/Gray read pointer, registered empty,
// almost-empty and level flags, plus a sticky underflow flag.
module rptr_empty #(
  parameter int ADDR_WIDTH    = 4,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic          rclk,
  input  logic          rrst_n,
  rptr_empty_if.slave   bus
);
  localparam int W = ADDR_WIDTH + 1;
  localparam logic [W-1:0] THRESH = W'(AEMPTY_THRESH);

  logic [W-1:0] rbin_q, rbin_d;
  logic [W-1:0] rptr_q, rptr_d;
  logic [W-1:0] rlevel_q, rlevel_d;
  logic         rempty_q, rempty_d;
  logic         raempty_q, raempty_d;
  logic         runderflow_q, runderflow_d;
  logic [W-1:0] wbin;
  logic         rd_ok;

  always_comb begin
    rd_ok  = bus.rinc & ~rempty_q;
    rbin_d = rbin_q + W'(rd_ok);
    rptr_d = (rbin_d >> 1) ^ rbin_d;

    // Gray to binary: each bit is the XOR of all Gray bits at or above it.
    wbin        = '0;
    wbin[W-1]   = bus.rq2_wptr[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      wbin[i] = wbin[i+1] ^ bus.rq2_wptr[i];
    end

    rlevel_d     = wbin - rbin_d;
    rempty_d     = (rptr_d == bus.rq2_wptr);
    raempty_d    = (rlevel_d <= THRESH);
    runderflow_d = (bus.rinc & rempty_q) | (runderflow_q & ~bus.clr_err);
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin_q       <= '0;
      rptr_q       <= '0;
      rlevel_q     <= '0;
      rempty_q     <= 1'b1;
      raempty_q    <= 1'b1;
      runderflow_q <= 1'b0;
    end else begin
      rbin_q       <= rbin_d;
      rptr_q       <= rptr_d;
      rlevel_q     <= rlevel_d;
      rempty_q     <= rempty_d;
      raempty_q    <= raempty_d;
      runderflow_q <= runderflow_d;
    end
  end

  assign bus.raddr      = rbin_q[ADDR_WIDTH-1:0];
  assign bus.rptr       = rptr_q;
  assign bus.rlevel     = rlevel_q;
  assign bus.rempty     = rempty_q;
  assign bus.raempty    = raempty_q;
  assign bus.runderflow = runderflow_q;
endmodule

// File: tb/tb_rptr_empty.sv
// Bench for rptr_empty: directed scenarios plus random traffic, checked
// against a count-based model (read/write counts modulo 32).
module tb_rptr_empty;
  localparam int AW = 4;

  logic rclk;
  logic rrst_n;

  rptr_empty_if #(.ADDR_WIDTH(AW)) bus ();

  rptr_empty #(.ADDR_WIDTH(AW), .AEMPTY_THRESH(2)) dut (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .bus    (bus)
  );

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  int vectors    = 0;
  int miscompares = 0;

  // Model: counts of reads and writes, everything else derived from them.
  int m_rd, m_wr, m_level;
  bit m_empty, m_aempty, m_uf;

  function automatic logic [4:0] gray5(input int b);
    logic [4:0] v;
    v = 5'(b);
    return v ^ (v >> 1);
  endfunction

  function automatic logic [16:0] exp_vec();
    return {4'(m_rd), gray5(m_rd), m_empty, m_aempty, 5'(m_level), m_uf};
  endfunction

  function automatic logic [16:0] act_vec();
    return {bus.raddr, bus.rptr, bus.rempty, bus.raempty, bus.rlevel, bus.runderflow};
  endfunction

  task automatic model_reset();
    m_rd = 0; m_level = 0; m_empty = 1; m_aempty = 1; m_uf = 0;
  endtask

  // Drive inputs at a falling edge, clock once, update the model, return at the next falling edge.
  task automatic apply(input bit r, input int w, input bit c);
    bit acc;
    bus.rinc     = r;
    bus.rq2_wptr = gray5(w);
    bus.clr_err  = c;
    @(posedge rclk);
    acc     = r && !m_empty;
    m_uf    = (r && m_empty) || (m_uf && !c);
    m_rd    = (m_rd + int'(acc)) & 31;
    m_wr    = w & 31;
    m_level = (m_wr - m_rd) & 31;
    m_empty = (m_level == 0);
    m_aempty = (m_level <= 2);
    @(negedge rclk);
  endtask

  task automatic test_reset();
    rrst_n = 1'b0;
    bus.rinc = 1'b0; bus.rq2_wptr = '0; bus.clr_err = 1'b0;
    m_wr = 0;
    model_reset();
    @(negedge rclk);
    vectors++;
    if (act_vec() !== {4'd0, 5'b00000, 1'b1, 1'b1, 5'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state: got %h want %h", act_vec(), {4'd0, 5'b00000, 1'b1, 1'b1, 5'd0, 1'b0});
    end
    rrst_n = 1'b1;
    apply(0, 0, 0);
    vectors++;
    if (act_vec() !== {4'd0, 5'b00000, 1'b1, 1'b1, 5'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL idle_after_reset: got %h want %h", act_vec(), {4'd0, 5'b00000, 1'b1, 1'b1, 5'd0, 1'b0});
    end
  endtask

  task automatic test_fill_drain();
    apply(0, 3, 0);
    vectors++;
    if ({bus.rempty, bus.rlevel, bus.raempty} !== {1'b0, 5'd3, 1'b0}) begin
      miscompares++;
      $display("FAIL wptr_step: got empty=%b level=%0d aempty=%b want 0 3 0", bus.rempty, bus.rlevel, bus.raempty);
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (bus.raddr !== 4'(i)) begin
        miscompares++;
        $display("FAIL drain_raddr[%0d]: got %0d want %0d", i, bus.raddr, i);
      end
      apply(1, 3, 0);
      vectors++;
      if ({bus.rlevel, bus.raempty} !== {5'(2 - i), 1'b1}) begin
        miscompares++;
        $display("FAIL drain_level[%0d]: got level=%0d aempty=%b want %0d 1", i, bus.rlevel, bus.raempty, 2 - i);
      end
    end
    vectors++;
    if ({bus.rempty, bus.rptr} !== {1'b1, 5'b00010} || act_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL drain_end: got %h want %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_underflow();
    apply(1, 3, 0);
    vectors++;
    if ({bus.rptr, bus.runderflow} !== {5'b00010, 1'b1}) begin
      miscompares++;
      $display("FAIL underflow_set: got rptr=%b uf=%b want 00010 1", bus.rptr, bus.runderflow);
    end
    apply(0, 3, 1);
    vectors++;
    if (bus.runderflow !== 1'b0) begin
      miscompares++;
      $display("FAIL underflow_clear: got %b want 0", bus.runderflow);
    end
    apply(1, 3, 0);
    apply(1, 3, 1);
    vectors++;
    if ({bus.runderflow, bus.rptr} !== {1'b1, 5'b00010}) begin
      miscompares++;
      $display("FAIL underflow_set_wins: got uf=%b rptr=%b want 1 00010", bus.runderflow, bus.rptr);
    end
    apply(0, 3, 1);
  endtask

  task automatic test_wrap();
    int w;
    int guard;
    guard = 0;
    while (m_rd != 31 && guard < 200) begin
      w = (m_rd + 8 > 31) ? 31 : m_rd + 8;
      apply(0, w, 0);
      while (!m_empty && guard < 200) begin
        apply(1, w, 0);
        guard++;
        vectors++;
        if (act_vec() !== exp_vec()) begin
          miscompares++;
          $display("FAIL wrap_walk: got %h want %h", act_vec(), exp_vec());
        end
      end
      guard++;
    end
    vectors++;
    if ({bus.rptr, bus.raddr, bus.rempty} !== {5'b10000, 4'd15, 1'b1}) begin
      miscompares++;
      $display("FAIL wrap_start: got rptr=%b raddr=%0d empty=%b want 10000 15 1", bus.rptr, bus.raddr, bus.rempty);
    end
    apply(0, 32, 0);
    vectors++;
    if ({bus.rempty, bus.rlevel} !== {1'b0, 5'd1}) begin
      miscompares++;
      $display("FAIL wrap_one_entry: got empty=%b level=%0d want 0 1", bus.rempty, bus.rlevel);
    end
    apply(1, 32, 0);
    vectors++;
    if ({bus.rptr, bus.raddr, bus.rempty, bus.rlevel} !== {5'b00000, 4'd0, 1'b1, 5'd0}) begin
      miscompares++;
      $display("FAIL wrap_read: got rptr=%b raddr=%0d empty=%b level=%0d want 00000 0 1 0",
               bus.rptr, bus.raddr, bus.rempty, bus.rlevel);
    end
  endtask

  task automatic test_random();
    int w;
    bit r, c;
    w = m_wr;
    for (int n = 0; n < 400; n++) begin
      if ((((w + 3) - m_rd) & 31) <= 16) w = (w + int'($urandom_range(0, 3))) & 31;
      else if ((((w + 1) - m_rd) & 31) <= 16) w = (w + int'($urandom_range(0, 1))) & 31;
      r = ($urandom_range(0, 99) < 60);
      c = ($urandom_range(0, 99) < 10);
      apply(r, w, c);
      vectors++;
      if (act_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random[%0d]: got %h want %h", n, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    apply(0, m_rd + 5, 0);
    vectors++;
    if (bus.rlevel !== 5'd5) begin
      miscompares++;
      $display("FAIL pre_reset_level: got %0d want 5", bus.rlevel);
    end
    #2 rrst_n = 1'b0;
    #1;
    vectors++;
    if (act_vec() !== {4'd0, 5'b00000, 1'b1, 1'b1, 5'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL async_reset: got %h want %h", act_vec(), {4'd0, 5'b00000, 1'b1, 1'b1, 5'd0, 1'b0});
    end
    model_reset();
    m_wr = 0;
    bus.rq2_wptr = '0;
    @(negedge rclk);
    rrst_n = 1'b1;
    apply(0, 2, 0);
    vectors++;
    if (act_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL post_reset: got %h want %h", act_vec(), exp_vec());
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_underflow();
    test_wrap();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rptr_empty.md
RPTR_EMPTY -- requirements
Module: rptr_empty

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 4, giving the FIFO address width (depth DEPTH = 2^ADDR_WIDTH).
REQ-002 The block SHALL have parameter AEMPTY_THRESH, default 2, giving the almost-empty level threshold in entries.
REQ-003 The block SHALL have port rclk, input, 1 bit: the read-domain clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rrst_n, input, 1 bit: the read-domain reset, asynchronous and active-low.
REQ-005 The block SHALL have port rinc, input, 1 bit: read request from the consumer.
REQ-006 The block SHALL have port rq2_wptr, input, ADDR_WIDTH+1 bits: the Gray-coded write pointer, already synchronized into rclk by the upstream two-flop stage.
REQ-007 The block SHALL have port clr_err, input, 1 bit: clears the underflow flag.
REQ-008 The block SHALL have port raddr, output, ADDR_WIDTH bits: the RAM read address.
REQ-009 The block SHALL have port rptr, output, ADDR_WIDTH+1 bits: the registered Gray read pointer, sent to the write-domain synchronizer.
REQ-010 The block SHALL have port rempty, output, 1 bit: FIFO empty, registered.
REQ-011 The block SHALL have port raempty, output, 1 bit: almost empty, registered.
REQ-012 The block SHALL have port rlevel, output, ADDR_WIDTH+1 bits: occupied-entry count seen from the read side, registered.
REQ-013 The block SHALL have port runderflow, output, 1 bit: sticky flag for a read attempted while empty.

Function
REQ-014 The block SHALL hold a binary read pointer rbin, ADDR_WIDTH+1 bits, with rbin_next = rbin + (rinc & ~rempty), modulo 2^(ADDR_WIDTH+1).
REQ-015 A read SHALL be accepted only when rinc=1 and rempty=0 at the rising edge; rinc while rempty=1 leaves rbin, rptr and raddr unchanged.
REQ-016 raddr SHALL equal rbin[ADDR_WIDTH-1:0], driven directly from the register with no added latency; the RAM is read at raddr in the cycle the read is accepted.
REQ-017 rptr SHALL be registered as rgray_next = (rbin_next >> 1) XOR rbin_next, so exactly one bit changes per accepted read.
REQ-018 rempty SHALL be registered as (rgray_next == rq2_wptr); the final read therefore asserts rempty at the same edge that advances the pointer.
REQ-019 The block SHALL convert rq2_wptr to binary wbin by XOR prefix from the MSB; rlevel SHALL be registered as (wbin - rbin_next) modulo 2^(ADDR_WIDTH+1).
REQ-020 raempty SHALL be registered as (level_next <= AEMPTY_THRESH), using the same level_next value that is loaded into rlevel.
REQ-021 runderflow SHALL be set on the edge following rinc=1 with rempty=1 and SHALL stay set until clr_err=1; when set and clear occur in the same cycle, set SHALL win.
REQ-022 Wrap-around: rbin SHALL roll from 2^(ADDR_WIDTH+1)-1 to 0, raddr SHALL roll from DEPTH-1 to 0, and the Gray MSB difference SHALL distinguish a full wrap from empty.
REQ-023 The block SHALL add no synchronizer flops on rq2_wptr; a change in rq2_wptr SHALL be reflected in rempty, rlevel and raempty one rclk after it appears.
REQ-024 Simultaneous change of rq2_wptr and an accepted read SHALL use both updated values in the same next-state computation.

Reset
REQ-025 When rrst_n=0, all registers SHALL take their reset values immediately, without a clock edge: rbin=0, rptr=0, raddr=0, rempty=1, raempty=1, rlevel=0, runderflow=0.
REQ-026 After rrst_n rises, normal operation SHALL resume on the first rclk edge; reset asserted mid-operation SHALL discard all pointer state.

Verification (ADDR_WIDTH=4, AEMPTY_THRESH=2)
REQ-027 Apply reset, then hold rq2_wptr=0 and rinc=0 -> rempty=1, raempty=1, rlevel=0, rptr=5'b00000, runderflow=0.
REQ-028 Step rq2_wptr=5'b00010 (gray of 3) with rinc=0 -> one edge later rempty=0, rlevel=3, raempty=0.
REQ-029 From that state, assert rinc for 3 cycles -> raddr reads 0,1,2; rlevel goes 2 (raempty=1), 1, 0; rempty=1 and rptr=5'b00010 after the 3rd edge.
REQ-030 With rempty=1, pulse rinc -> rptr is unchanged and runderflow=1 on the next edge; pulse clr_err -> runderflow=0; drive rinc and clr_err together while empty -> runderflow stays 1.
REQ-031 Wrap test: with rbin=31 (rptr=5'b10000, raddr=15) and one entry available, perform 1 read -> rbin=0, rptr=5'b00000, raddr=0, and rempty set correctly.
REQ-032 With rlevel=5, drop rrst_n between clock edges -> all outputs reach their reset values before the next rclk edge.
